// File: rtl/nibble_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the nibble-serial adder controller:
//   NIBBLE_W     - width of one datapath slice (the 4-bit adder)
//   add_state_t  - controller state encoding (IDLE, ADD, DONE)
// ---------------------------------------------------------------------------
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } add_state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_four_bit_adder.sv
// ---------------------------------------------------------------------------
// four_bit_adder
// Purely combinational 4-bit ripple slice used as the shared datapath of the
// nibble-serial adder.
// Ports:
//   a, b  in  4  slice operands
//   cin   in  1  carry into the slice
//   s     out 4  slice sum
//   cout  out 1  carry out of the slice
// ---------------------------------------------------------------------------
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign s     = total[3:0];
    assign cout  = total[4];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl
// Adds two W = 4*NUM_NIBBLES bit operands through a single four_bit_adder,
// one nibble per clock, least significant nibble first. Operands are
// captured on an accepted start; the result is published together with a
// one-cycle done pulse and held until the next result.
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the ovf output
// (two's-complement overflow of the W-bit add, registered with sum).
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request, sampled only in IDLE
//   a, b   in   W  operands, captured when start is accepted
//   cin    in   1  carry into nibble 0, captured with the operands
//   busy   out  1  high while in ADD or DONE
//   done   out  1  one-cycle pulse, sum/cout valid
//   sum    out  W  result, held until the next result
//   cout   out  1  carry out of the top nibble, held with sum
//   ovf    out  1  (SERIAL_ADD_OVF_EN only) signed overflow, held with sum
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NUM_NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [4*NUM_NIBBLES-1:0]    a,
    input  logic [4*NUM_NIBBLES-1:0]    b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [4*NUM_NIBBLES-1:0]    sum,
    output logic                        cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W     = NIBBLE_W * NUM_NIBBLES;
    localparam int IDX_W = $clog2(NUM_NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

    add_state_t         state_q,  state_d;
    logic [W-1:0]       a_sh_q,   a_sh_d;
    logic [W-1:0]       b_sh_q,   b_sh_d;
    logic [W-1:0]       sum_sh_q, sum_sh_d;
    logic               carry_q,  carry_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [W-1:0]       sum_q,    sum_d;
    logic               cout_q,   cout_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               ovf_q,    ovf_d;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;

    four_bit_adder u_slice (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;        // done is a pulse; only the ADD->DONE step raises it
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    carry_d  = cin;
                    idx_d    = '0;
                    sum_sh_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ADD;
                end
            end

            ADD: begin
                // Result nibbles enter from the top, so after NUM_NIBBLES
                // steps nibble 0 has migrated down to the LSB position.
                sum_sh_d = {slice_s, sum_sh_q[W-1:NIBBLE_W]};
                carry_d  = slice_co;
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d   = sum_sh_d;
                    cout_d  = slice_co;
                    // On the last step the low nibble of each shift register
                    // holds the operand's top nibble, so bit 3 is its sign.
                    ovf_d   = (a_sh_q[NIBBLE_W-1] == b_sh_q[NIBBLE_W-1]) &&
                              (slice_s[NIBBLE_W-1] != a_sh_q[NIBBLE_W-1]);
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADD_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_add_ctrl
// Directed bench for nibble_serial_add_ctrl (NUM_NIBBLES=4, W=16).
// Expected results are pushed to a queue when an add is started and popped
// when done is seen. Define SERIAL_ADD_OVF_EN to exercise ovf as well.
// ---------------------------------------------------------------------------
module tb_nibble_serial_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad   = 0;

    // {ovf, cout, sum}
    logic [W+1:0] exp_q[$];
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NUM_NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_in),
        .b     (b_in),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: full-width addition plus sign-overflow rule.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        logic       v;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        exp_q.push_back({v, full});
    endtask

    // Called at the negedge of cycle 1 after the accepting edge.
    task automatic wait_result(input string tag);
        logic [W+1:0] e;
        int k;
        k = 1;
        while (k <= 20 && done !== 1'b1) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " sum_stable"}, 32'({cout, sum}), 32'({prev_cout, prev_sum}));
            @(negedge clk);
            k++;
        end
        check({tag, " done_cycle"}, k, N + 1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, " queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " sum"}, 32'(sum), 32'(e[W-1:0]));
            check({tag, " cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADD_OVF_EN
            check({tag, " ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
            $display("txn %s: sum=0x%04h cout=%0d", tag, sum, cout);
        end
        prev_sum  = sum;
        prev_cout = cout;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " held"}, 32'({cout, sum}), 32'({prev_cout, prev_sum}));
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        push_exp(a, b, c);
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;          // must not influence the add in flight
        b_in  = ~b;
        wait_result(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = '0;
        b_in      = '0;
        cin       = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;

        // 1: reset state, idle with no start
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst busy", 32'(busy), 32'd0);
            check("rst done", 32'(done), 32'd0);
            check("rst sum", 32'(sum), 32'd0);
            check("rst cout", 32'(cout), 32'd0);
        end

        // 2, 3: basic and carry-chain adds
        run_add("add_1234_4321", 16'h1234, 16'h4321, 1'b0);
        run_add("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
        run_add("add_ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1);
        run_add("add_0000_0000_c", 16'h0000, 16'h0000, 1'b1);

        // 4: start held and operands changed while busy
        a_in  = 16'h0F0F;
        b_in  = 16'h0101;
        cin   = 1'b0;
        start = 1'b1;
        push_exp(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        a_in = 16'hAAAA;
        b_in = 16'hAAAA;
        wait_result("held_start");
        // start still high in IDLE: the next edge takes the 0xAAAA operands
        push_exp(16'hAAAA, 16'hAAAA, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_result("held_start_2nd");

        // 5: reset in the middle of ADD
        a_in  = 16'h1111;
        b_in  = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            check("abort no_done", seen, 0);
            check("abort idle", 32'(busy), 32'd0);
        end
        prev_sum  = '0;
        prev_cout = 1'b0;
        $display("txn abort: busy=%0d sum=0x%04h", busy, sum);

        // 6: overflow cases (ovf checked only when the feature is built)
        run_add("ovf_7fff_0001", 16'h7FFF, 16'h0001, 1'b0);
        run_add("ovf_8000_8000", 16'h8000, 16'h8000, 1'b0);
        run_add("ovf_none", 16'h0123, 16'h0456, 1'b0);

        // Random adds, back-to-back from IDLE
        for (int i = 0; i < 6; i++) begin
            run_add("rand", W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end

        check("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
